question_sequencer: RTL

// - Upstream stage of the OBC error-checking path: issues pseudo-random 4-bit questions to the OBC at a fixed cadence.
// - Waits for the OBC answer and enforces a response timeout.
// - Hands each {question, answerOBC} pair to the answer-check stage as a one-cycle valid pulse.

---
 rtl/error_checking_pkg.sv | 32 +++
 rtl/question_lfsr.sv | 35 +++
 rtl/question_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/error_checking_pkg.sv
// error_checking_pkg
// Shared definitions for the OBC error-checking path: question width,
// sequencer state encoding, LFSR feedback taps, default seed and the
// LFSR step/seed helpers used by question_lfsr.
package error_checking_pkg;

  localparam int QWIDTH = 4;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_PERIOD = 3'd1,
    S_ISSUE       = 3'd2,
    S_AWAIT       = 3'd3,
    S_DELIVER     = 3'd4
  } qseq_state_e;

  // x^4 + x^3 + 1 Fibonacci feedback taps
  localparam int LFSR_TAP_A = 3;
  localparam int LFSR_TAP_B = 2;

  localparam logic [QWIDTH-1:0] LFSR_DEFAULT_SEED = 4'b0001;

  function automatic logic [QWIDTH-1:0] lfsr_next(input logic [QWIDTH-1:0] q);
    return {q[QWIDTH-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
  endfunction

  // The all-zero state is a lock-up state for this LFSR, so never seed it.
  function automatic logic [QWIDTH-1:0] lfsr_fix_seed(input logic [QWIDTH-1:0] s);
    return (s == '0) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/question_lfsr.sv
// question_lfsr
// 4-bit maximal-length Fibonacci LFSR (period 15, never 0) that supplies
// question values.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset, loads the (fixed-up) seed
//   advance  in   step the LFSR by one on this clock edge
//   seed     in   reset value; 0 is replaced by the default seed
//   value    out  current LFSR state
module question_lfsr
  import error_checking_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  input  logic [QWIDTH-1:0] seed,
  output logic [QWIDTH-1:0] value
);

  logic [QWIDTH-1:0] value_q;
  logic [QWIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) value_d = lfsr_next(value_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value_q <= lfsr_fix_seed(seed);
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/question_sequencer.sv
// question_sequencer
// Issues pseudo-random questions to the OBC at a fixed cadence, waits for
// the answer under a timeout, and hands each {question, answer} pair to the
// answer-check stage as a one-cycle chk_valid pulse.
// Ports:
//   clk, reset_n                  clock / asynchronous active-low reset
//   enable                        run request from supervisor FSM
//   question, question_valid      outstanding question to the OBC
//   answer_obc, answer_obc_valid  OBC answer and strobe (used only in AWAIT)
//   chk_question, chk_answer      pair delivered to the check stage
//   chk_valid                     one-cycle pulse, chk_* valid
//   timeout                       one-cycle pulse, OBC did not answer in time
//   busy                          high whenever not IDLE
// Build option: define QSEQ_STATS_EN to add the saturating issued_count and
// timeout_count outputs.
// All outputs come straight from flops.
module question_sequencer
  import error_checking_pkg::*;
#(
  parameter int                PERIOD_CYCLES  = 16,
  parameter int                TIMEOUT_CYCLES = 64,
  parameter logic [QWIDTH-1:0] LFSR_SEED      = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [QWIDTH-1:0] question,
  output logic              question_valid,
  input  logic [QWIDTH-1:0] answer_obc,
  input  logic              answer_obc_valid,
  output logic [QWIDTH-1:0] chk_question,
  output logic [QWIDTH-1:0] chk_answer,
  output logic              chk_valid,
  output logic              timeout,
  output logic              busy
`ifdef QSEQ_STATS_EN
  ,
  output logic [7:0]        issued_count,
  output logic [7:0]        timeout_count
`endif
);

  localparam int CNT_MAX = (PERIOD_CYCLES > TIMEOUT_CYCLES) ? PERIOD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] PERIOD_LOAD  = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  qseq_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [QWIDTH-1:0] question_q, question_d;
  logic              question_valid_q, question_valid_d;
  logic [QWIDTH-1:0] chk_question_q, chk_question_d;
  logic [QWIDTH-1:0] chk_answer_q, chk_answer_d;
  logic              chk_valid_q, chk_valid_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;

  logic              lfsr_adv;
  logic [QWIDTH-1:0] lfsr_value;

  question_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (lfsr_adv),
    .seed    (LFSR_SEED),
    .value   (lfsr_value)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    question_d       = question_q;
    question_valid_d = question_valid_q;
    chk_question_d   = chk_question_q;
    chk_answer_d     = chk_answer_q;
    chk_valid_d      = 1'b0;
    timeout_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT_PERIOD;
          cnt_d   = PERIOD_LOAD;
        end
      end
      S_WAIT_PERIOD: begin
        if (!enable)            state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_ISSUE;
        else                    cnt_d   = cnt_q - CW'(1);
      end
      S_ISSUE: begin
        // LFSR already stepped on entry, so its value is the new question.
        question_d       = lfsr_value;
        question_valid_d = 1'b1;
        cnt_d            = TIMEOUT_LOAD;
        state_d          = S_AWAIT;
      end
      S_AWAIT: begin
        // An answer on the final timeout cycle still wins over the timeout.
        if (answer_obc_valid) begin
          chk_answer_d     = answer_obc;
          chk_question_d   = question_q;
          chk_valid_d      = 1'b1;
          question_valid_d = 1'b0;
          state_d          = S_DELIVER;
        end else if (cnt_q == '0) begin
          timeout_d        = 1'b1;
          question_valid_d = 1'b0;
          if (enable) begin
            state_d = S_WAIT_PERIOD;
            cnt_d   = PERIOD_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DELIVER: begin
        if (enable) begin
          state_d = S_WAIT_PERIOD;
          cnt_d   = PERIOD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    lfsr_adv = (state_d == S_ISSUE) && (state_q != S_ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      question_q       <= '0;
      question_valid_q <= 1'b0;
      chk_question_q   <= '0;
      chk_answer_q     <= '0;
      chk_valid_q      <= 1'b0;
      timeout_q        <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      question_q       <= question_d;
      question_valid_q <= question_valid_d;
      chk_question_q   <= chk_question_d;
      chk_answer_q     <= chk_answer_d;
      chk_valid_q      <= chk_valid_d;
      timeout_q        <= timeout_d;
      busy_q           <= busy_d;
    end
  end

  assign question       = question_q;
  assign question_valid = question_valid_q;
  assign chk_question   = chk_question_q;
  assign chk_answer     = chk_answer_q;
  assign chk_valid      = chk_valid_q;
  assign timeout        = timeout_q;
  assign busy           = busy_q;

`ifdef QSEQ_STATS_EN
  // Saturating event counters; only reset_n clears them.
  logic [7:0] issued_q, issued_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    issued_d  = issued_q;
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_ISSUE && issued_q != 8'hFF) issued_d  = issued_q + 8'd1;
    if (timeout_d && tmo_cnt_q != 8'hFF)         tmo_cnt_d = tmo_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q  <= '0;
      tmo_cnt_q <= '0;
    end else begin
      issued_q  <= issued_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign issued_count  = issued_q;
  assign timeout_count = tmo_cnt_q;
`endif

endmodule
